secure_reg_reader: RTL and testbench
====================================

// Module: secure_reg_reader
// PURPOSE
//  Access-controlled read port for a small protected register bank; the read-side counterpart of the usr_id-gated write path.
//  Accepts a read request tagged with usr_id and authorises it against the id sampled in the same cycle (no stale grant).
//  Returns a snapshot of the addressed register on a valid/ready response channel.
//  Repeated denied reads trigger a timed lockout.
// PARAMETERS
//  DATA_W       8    register / read data width
//  ADDR_W       2    bank address width (2**ADDR_W registers)
//  ID_W         3    user id width
//  AUTH_ID      3'h4 only id permitted to read
//  LOCK_THRESH  3    consecutive denials that trigger lockout (>=1)
//  LOCK_CYCLES  16   lockout duration in clk cycles (>=1)
// PORTS
//  clk        in   1                   clock, all logic on rising edge
//  rst_n      in   1                   asynchronous active-low reset
//  bank_data  in   DATA_W*2**ADDR_W    flattened register bank, reg i at [i*DATA_W +: DATA_W]
//  rd_req     in   1                   read request
//  rd_addr    in   ADDR_W              register index, valid with rd_req
//  usr_id     in   ID_W                requester id, valid with rd_req
//  rd_req_rdy out  1                   request accepted when rd_req && rd_req_rdy
//  rd_valid   out  1                   response valid
//  rd_data    out  DATA_W              response data (0 when denied)
//  rd_err     out  1                   response is a denial
//  rd_ready   in   1                   consumer accepts response
//  locked     out  1                   lockout active
//  audit_id   out  ID_W                last denied id (AUDIT_LOG_EN only, else 0)
//  audit_addr out  ADDR_W              last denied address (AUDIT_LOG_EN only, else 0)
//  audit_cnt  out  8                   saturating denial count (AUDIT_LOG_EN only, else 0)
// BEHAVIOUR
//  - Reset: state IDLE; rd_valid=0, rd_data=0, rd_err=0, locked=0, rd_req_rdy=1; deny counter=0; lock timer=0; audit outputs=0.
//    Reset asserted mid-transaction discards the pending response; no partial state survives.
//  - FSM states:
//    - IDLE: rd_req_rdy=1. On rd_req, grant = (usr_id==AUTH_ID), evaluated from the same-cycle usr_id.
//      - Granted: rd_data <= bank_data[rd_addr], rd_err<=0, deny counter cleared.
//      - Denied: rd_data<=0, rd_err<=1, deny counter +1 (saturates at LOCK_THRESH).
//      - Next state RESP.
//    - RESP: rd_valid=1; rd_data/rd_err held stable until rd_valid && rd_ready.
//      - On handshake: if deny counter==LOCK_THRESH, go to LOCKED (timer=LOCK_CYCLES, counter cleared); else IDLE.
//    - LOCKED: locked=1, rd_req_rdy=0; rd_req ignored and never queued; timer decrements each cycle; at 1 go to IDLE.
//      locked is high for exactly LOCK_CYCLES cycles.
//  - Latency: request accepted cycle N -> rd_valid high cycle N+1. Data is the bank snapshot at cycle N; later bank changes do not affect it.
//  - rd_req_rdy=0 in RESP and LOCKED; at most one outstanding request; no back-to-back acceptance.
//    After a handshake in cycle M, the earliest next accept is cycle M+1.
//  - rd_valid && rd_ready in the first RESP cycle completes the transaction in that cycle.
//  - The denial that reaches LOCK_THRESH is still delivered as rd_err=1 before lockout begins.
//  - A granted read between denials clears the counter (denials must be consecutive).
//  - rd_addr is always in range (power-of-two bank); no address error exists.
//  - Denied responses never expose bank contents: rd_data==0 whenever rd_err==1.
// CONFIGURATION
//  AUDIT_LOG_EN defined:
//   - On each denied acceptance, audit_id<=usr_id and audit_addr<=rd_addr.
//   - audit_cnt increments, saturating at 8'hFF; cleared only by reset.
//  AUDIT_LOG_EN undefined: audit ports remain present, tied to 0; no audit registers are built.
// TESTING
//  1. bank reg2=8'hA5, req addr=2 id=4, rd_ready=1 -> next cycle rd_valid=1, rd_data=8'hA5, rd_err=0.
//  2. req addr=1 id=3 -> rd_valid=1, rd_err=1, rd_data=8'h00; locked=0.
//  3. Three consecutive denied reads (id=0,5,7) -> third gets rd_err=1; then locked=1 for 16 cycles, rd_req_rdy=0; a req during lockout gets no response.
//  4. Denied, denied, granted (id=4), denied -> no lockout; counter ends at 1.
//  5. Granted req, hold rd_ready=0 for 5 cycles while bank reg changes 8'h11->8'h22 -> rd_data stays 8'h11 until handshake.
//  6. rst_n low during RESP and LOCKED -> all outputs at reset values next edge; with AUDIT_LOG_EN, a denial by id=6 addr=3 gives audit_id=6, audit_addr=3, audit_cnt=1.

Source files
------------

// File: rtl/secure_reg_reader.sv
// secure_reg_reader: access-controlled read port for a small protected register bank.
// A read request is authorised against the usr_id presented in the same cycle. The
// addressed register is snapshotted into the response, which is held on a valid/ready
// channel until it is accepted. A run of consecutive denied reads starts a timed lockout.
//
// Optional feature macro: AUDIT_LOG_EN builds the last-denial audit log. When the macro
// is undefined, the audit ports are still present but are tied to 0.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   bank_data    flattened register bank; register i is at [i*DATA_W +: DATA_W]
//   rd_req       read request; rd_addr and usr_id are valid with it
//   rd_req_rdy   request accepted when rd_req && rd_req_rdy
//   rd_valid     response valid; rd_data and rd_err are held until rd_ready
//   rd_data      response data (0 on denial)
//   rd_err       response is a denial
//   rd_ready     consumer accepts the response
//   locked       lockout in progress
//   audit_id     last denied id (0 unless AUDIT_LOG_EN is defined)
//   audit_addr   last denied address (0 unless AUDIT_LOG_EN is defined)
//   audit_cnt    saturating denial count (0 unless AUDIT_LOG_EN is defined)
module secure_reg_reader #(
    parameter int unsigned     DATA_W      = 8,
    parameter int unsigned     ADDR_W      = 2,
    parameter int unsigned     ID_W        = 3,
    parameter logic [ID_W-1:0] AUTH_ID     = 'h4,
    parameter int unsigned     LOCK_THRESH = 3,
    parameter int unsigned     LOCK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W*(2**ADDR_W)-1:0] bank_data,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic [ID_W-1:0]               usr_id,
    output logic                          rd_req_rdy,
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_err,
    input  logic                          rd_ready,
    output logic                          locked,
    output logic [ID_W-1:0]               audit_id,
    output logic [ADDR_W-1:0]             audit_addr,
    output logic [7:0]                    audit_cnt
);

    localparam int unsigned NREGS = 2 ** ADDR_W;
    localparam int unsigned CNT_W = $clog2(LOCK_THRESH + 1);
    localparam int unsigned TMR_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_err_q, rd_err_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_req_rdy_q, rd_req_rdy_d;
    logic               locked_q, locked_d;
    logic [CNT_W-1:0]   deny_cnt_q, deny_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               grant_c;

    // Unflatten the bank so the read mux is a plain array index.
    logic [DATA_W-1:0]  bank_arr [NREGS];
    for (genvar i = 0; i < NREGS; i++) begin : g_bank
        assign bank_arr[i] = bank_data[i*DATA_W +: DATA_W];
    end

    // Authorisation uses the id presented in the accepting cycle only.
    assign grant_c = (usr_id == AUTH_ID);

    // Next-state and response logic.
    always_comb begin
        state_d    = state_q;
        rd_data_d  = rd_data_q;
        rd_err_d   = rd_err_q;
        deny_cnt_d = deny_cnt_q;
        timer_d    = timer_q;

        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d = RESP;
                    if (grant_c) begin
                        rd_data_d  = bank_arr[rd_addr];
                        rd_err_d   = 1'b0;
                        deny_cnt_d = '0;
                    end else begin
                        rd_data_d = '0;
                        rd_err_d  = 1'b1;
                        if (deny_cnt_q != CNT_W'(LOCK_THRESH)) begin
                            deny_cnt_d = deny_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            RESP: begin
                if (rd_ready) begin
                    // Drop the payload once consumed so nothing lingers on the bus.
                    rd_data_d = '0;
                    rd_err_d  = 1'b0;
                    if (deny_cnt_q == CNT_W'(LOCK_THRESH)) begin
                        state_d    = LOCKED;
                        timer_d    = TMR_W'(LOCK_CYCLES);
                        deny_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCKED: begin
                // Timer runs LOCK_CYCLES..1, one cycle each, so lockout lasts LOCK_CYCLES cycles.
                timer_d = timer_q - TMR_W'(1);
                if (timer_q == TMR_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state.
        rd_valid_d   = (state_d == RESP);
        rd_req_rdy_d = (state_d == IDLE);
        locked_d     = (state_d == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rd_data_q    <= '0;
            rd_err_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_req_rdy_q <= 1'b1;
            locked_q     <= 1'b0;
            deny_cnt_q   <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            rd_data_q    <= rd_data_d;
            rd_err_q     <= rd_err_d;
            rd_valid_q   <= rd_valid_d;
            rd_req_rdy_q <= rd_req_rdy_d;
            locked_q     <= locked_d;
            deny_cnt_q   <= deny_cnt_d;
            timer_q      <= timer_d;
        end
    end

    assign rd_req_rdy = rd_req_rdy_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_err     = rd_err_q;
    assign locked     = locked_q;

`ifdef AUDIT_LOG_EN
    logic              deny_accept_c;
    logic [ID_W-1:0]   audit_id_q, audit_id_d;
    logic [ADDR_W-1:0] audit_addr_q, audit_addr_d;
    logic [7:0]        audit_cnt_q, audit_cnt_d;

    assign deny_accept_c = (state_q == IDLE) && rd_req && !grant_c;

    // Record the most recent denial; the count saturates and only reset clears it.
    always_comb begin
        audit_id_d   = audit_id_q;
        audit_addr_d = audit_addr_q;
        audit_cnt_d  = audit_cnt_q;
        if (deny_accept_c) begin
            audit_id_d   = usr_id;
            audit_addr_d = rd_addr;
            if (audit_cnt_q != 8'hFF) begin
                audit_cnt_d = audit_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audit_id_q   <= '0;
            audit_addr_q <= '0;
            audit_cnt_q  <= '0;
        end else begin
            audit_id_q   <= audit_id_d;
            audit_addr_q <= audit_addr_d;
            audit_cnt_q  <= audit_cnt_d;
        end
    end

    assign audit_id   = audit_id_q;
    assign audit_addr = audit_addr_q;
    assign audit_cnt  = audit_cnt_q;
`else
    assign audit_id   = '0;
    assign audit_addr = '0;
    assign audit_cnt  = '0;
`endif

endmodule

// File: tb/tb_secure_reg_reader.sv
// Scoreboard bench for secure_reg_reader: the driver pushes the expected response at
// acceptance; a monitor compares every valid response cycle against the queue head.
module tb_secure_reg_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] bank_data;
    logic        rd_req = 1'b0;
    logic [1:0]  rd_addr = '0;
    logic [2:0]  usr_id = '0;
    logic        rd_req_rdy;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_err;
    logic        rd_ready = 1'b1;
    logic        locked;
    logic [2:0]  audit_id;
    logic [1:0]  audit_addr;
    logic [7:0]  audit_cnt;

    logic [7:0]  bank [4];
    logic [8:0]  exp_q [$];   // {err, data}
    int          n_tests = 0;
    int          n_fail  = 0;
    int          lock_cnt;

    assign bank_data = {bank[3], bank[2], bank[1], bank[0]};

    secure_reg_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bank_data  (bank_data),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .usr_id     (usr_id),
        .rd_req_rdy (rd_req_rdy),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .rd_ready   (rd_ready),
        .locked     (locked),
        .audit_id   (audit_id),
        .audit_addr (audit_addr),
        .audit_cnt  (audit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every valid cycle must show the queue head; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got data 0x%0h err %0b with nothing outstanding at %0t",
                         rd_data, rd_err, $time);
            end else begin
                chk("rsp_data", 32'(rd_data), 32'(exp_q[0][7:0]));
                chk("rsp_err", 32'(rd_err), 32'(exp_q[0][8]));
                if (rd_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Issue one request (called just after a rising edge); returns just after the accept edge.
    task automatic do_req(input logic [1:0] a, input logic [2:0] id,
                          input logic [7:0] ed, input logic ee);
        int n = 0;
        rd_addr = a;
        usr_id  = id;
        rd_req  = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_req_rdy && n < 60);
        if (!rd_req_rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: rd_req_rdy stayed 0 for %0d cycles", n);
        end else begin
            exp_q.push_back({ee, ed});
        end
        @(posedge clk);
        #1 rd_req = 1'b0;
    endtask

    // Wait until the outstanding response is handed off; returns just after the handshake edge.
    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_timeout: %0d responses still pending", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    // Count lockout cycles; optionally holds a request during the first cycles of lockout.
    task automatic wait_unlock(input logic poke, output int cnt);
        cnt = 0;
        if (poke) begin
            rd_req  = 1'b1;
            rd_addr = 2'd2;
            usr_id  = 3'd4;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!locked) break;
            cnt++;
            chk("lock_rdy_low", 32'(rd_req_rdy), 32'd0);
            chk("lock_no_valid", 32'(rd_valid), 32'd0);
            if (i == 8) rd_req = 1'b0;
        end
        rd_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_valid"}, 32'(rd_valid), 32'd0);
        chk({nm, "_data"}, 32'(rd_data), 32'd0);
        chk({nm, "_err"}, 32'(rd_err), 32'd0);
        chk({nm, "_locked"}, 32'(locked), 32'd0);
        chk({nm, "_rdy"}, 32'(rd_req_rdy), 32'd1);
        chk({nm, "_audit"}, {16'd0, audit_cnt, 3'd0, audit_id, audit_addr}, 32'd0);
    endtask

    initial begin
        bank[0] = 8'h3C;
        bank[1] = 8'h5A;
        bank[2] = 8'hA5;
        bank[3] = 8'hC3;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("after_reset");

        // 1: authorised read of reg2
        do_req(2'd2, 3'd4, 8'hA5, 1'b0);
        chk("t1_valid_next_cycle", 32'(rd_valid), 32'd1);
        wait_done();

        // 2: denied read does not expose data and does not lock
        do_req(2'd1, 3'd3, 8'h00, 1'b1);
        wait_done();
        chk("t2_not_locked", 32'(locked), 32'd0);

        // A grant clears the one denial above before the lockout run.
        do_req(2'd3, 3'd4, 8'hC3, 1'b0);
        wait_done();

        // 3: three consecutive denials -> lockout of 16 cycles, request ignored
        do_req(2'd0, 3'd0, 8'h00, 1'b1);
        wait_done();
        chk("t3_d1_not_locked", 32'(locked), 32'd0);
        do_req(2'd1, 3'd5, 8'h00, 1'b1);
        wait_done();
        chk("t3_d2_not_locked", 32'(locked), 32'd0);
        do_req(2'd2, 3'd7, 8'h00, 1'b1);
        wait_done();
        chk("t3_locked", 32'(locked), 32'd1);
        wait_unlock(1'b1, lock_cnt);
        chk("t3_lock_cycles", 32'(lock_cnt), 32'd16);
        chk("t3_rdy_after_lock", 32'(rd_req_rdy), 32'd1);

        // 4: D, D, G, D leaves one denial; one more D still no lock, the next locks
        do_req(2'd0, 3'd1, 8'h00, 1'b1);
        wait_done();
        do_req(2'd1, 3'd2, 8'h00, 1'b1);
        wait_done();
        do_req(2'd1, 3'd4, 8'h5A, 1'b0);
        wait_done();
        do_req(2'd3, 3'd6, 8'h00, 1'b1);
        wait_done();
        chk("t4_no_lock_after_dgd", 32'(locked), 32'd0);
        do_req(2'd3, 3'd0, 8'h00, 1'b1);
        wait_done();
        chk("t4_no_lock_at_two", 32'(locked), 32'd0);
        do_req(2'd3, 3'd0, 8'h00, 1'b1);
        wait_done();
        chk("t4_lock_at_three", 32'(locked), 32'd1);
        wait_unlock(1'b0, lock_cnt);
        chk("t4_lock_cycles", 32'(lock_cnt), 32'd16);

        // 5: response held under backpressure while the bank changes
        bank[0]  = 8'h11;
        rd_ready = 1'b0;
        do_req(2'd0, 3'd4, 8'h11, 1'b0);
        repeat (2) @(posedge clk);
        bank[0] = 8'h22;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_still_valid", 32'(rd_valid), 32'd1);
        chk("t5_held_data", 32'(rd_data), 32'h11);
        rd_ready = 1'b1;
        wait_done();
        chk("t5_idle_after", 32'(rd_req_rdy), 32'd1);

        // 6a: reset during RESP discards the response
        rd_ready = 1'b0;
        do_req(2'd2, 3'd4, 8'hA5, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_outputs("t6_rst_resp");
        rd_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 6b: reset during LOCKED
        do_req(2'd0, 3'd0, 8'h00, 1'b1);
        wait_done();
        do_req(2'd0, 3'd1, 8'h00, 1'b1);
        wait_done();
        do_req(2'd0, 3'd2, 8'h00, 1'b1);
        wait_done();
        chk("t6_locked_before_rst", 32'(locked), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_rst_locked");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Port usable straight after reset; audit reflects a single denial.
        do_req(2'd3, 3'd6, 8'h00, 1'b1);
        wait_done();
        chk("t6_no_lock_after_one", 32'(locked), 32'd0);
`ifdef AUDIT_LOG_EN
        chk("audit_id", 32'(audit_id), 32'd6);
        chk("audit_addr", 32'(audit_addr), 32'd3);
        chk("audit_cnt", 32'(audit_cnt), 32'd1);
`else
        chk("audit_id_tied", 32'(audit_id), 32'd0);
        chk("audit_addr_tied", 32'(audit_addr), 32'd0);
        chk("audit_cnt_tied", 32'(audit_cnt), 32'd0);
`endif
        do_req(2'd1, 3'd4, 8'h5A, 1'b0);
        wait_done();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
